// File: rtl/alu_register_bank_if.sv
// Register-file / ALU bus: read and write ports on the register bank plus the ALU opcode, results and status flags.
interface alu_register_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic              write_enable;
  logic [3:0]        opcode;
  logic [DATA_W-1:0] data_out1;
  logic [DATA_W-1:0] data_out2;
  logic [DATA_W-1:0] alu_result;
  logic              zero_flag;
  logic              carry_flag;
  logic              overflow_flag;
  logic              negative_flag;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, write_enable, opcode,
    input  data_out1, data_out2, alu_result, zero_flag, carry_flag, overflow_flag, negative_flag
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, write_enable, opcode,
    output data_out1, data_out2, alu_result, zero_flag, carry_flag, overflow_flag, negative_flag
  );
endinterface

// File: rtl/alu_register_bank.sv
// 2**ADDR_W x DATA_W register bank (two async reads, one sync write) feeding a combinational ALU.
// Optional: define REG_ZERO_HARDWIRED_EN to make R0 read as zero and ignore writes to it.
module alu_register_bank #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input logic                clk,
  input logic                rst,
  alu_register_bank_if.slave bus
);
  localparam int NREG = 2**ADDR_W;
  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
                         OP_XOR  = 4'h4, OP_NOR  = 4'h5, OP_NOT  = 4'h6, OP_SLL  = 4'h7,
                         OP_SRL  = 4'h8, OP_SRA  = 4'h9, OP_SLT  = 4'hA, OP_SLTU = 4'hB,
                         OP_INC  = 4'hC, OP_DEC  = 4'hD, OP_PASA = 4'hE, OP_PASB = 4'hF;

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_ok;

`ifdef REG_ZERO_HARDWIRED_EN
  assign wr_ok         = bus.write_enable && (bus.write_reg != '0);
  assign bus.data_out1 = (bus.read_reg1 == '0) ? '0 : regs[bus.read_reg1];
  assign bus.data_out2 = (bus.read_reg2 == '0) ? '0 : regs[bus.read_reg2];
`else
  assign wr_ok         = bus.write_enable;
  assign bus.data_out1 = regs[bus.read_reg1];
  assign bus.data_out2 = regs[bus.read_reg2];
`endif

  // Reset preloads each register with its own index so operands are meaningful straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= DATA_W'(i);
    end else if (wr_ok) begin
      regs[bus.write_reg] <= bus.write_data;
    end
  end

  logic [DATA_W-1:0] a, b, op2, res;
  logic [DATA_W:0]   add_w, sub_w;
  logic              carry, ovf;

  assign a     = bus.data_out1;
  assign b     = bus.data_out2;
  // INC/DEC reuse the adder/subtractor with a constant 1 second operand.
  assign op2   = (bus.opcode == OP_INC || bus.opcode == OP_DEC) ? DATA_W'(1) : b;
  assign add_w = {1'b0, a} + {1'b0, op2};
  assign sub_w = {1'b0, a} - {1'b0, op2};

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_INC: begin
        res   = add_w[DATA_W-1:0];
        carry = add_w[DATA_W];
        ovf   = (a[DATA_W-1] == op2[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_SUB, OP_DEC: begin
        res   = sub_w[DATA_W-1:0];
        carry = ~sub_w[DATA_W];
        ovf   = (a[DATA_W-1] != op2[DATA_W-1]) && (res[DATA_W-1] != a[DATA_W-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOR:  res = ~(a | b);
      OP_NOT:  res = ~a;
      OP_SLL:  res = a << b[SH_W-1:0];
      OP_SRL:  res = a >> b[SH_W-1:0];
      OP_SRA:  res = DATA_W'($signed(a) >>> b[SH_W-1:0]);
      OP_SLT:  res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: res = {{(DATA_W-1){1'b0}}, (a < b)};
      OP_PASA: res = a;
      OP_PASB: res = b;
      default: res = '0;
    endcase
  end

  assign bus.alu_result    = res;
  assign bus.zero_flag     = (res == '0);
  assign bus.negative_flag = res[DATA_W-1];
  assign bus.carry_flag    = carry;
  assign bus.overflow_flag = ovf;
endmodule

// File: tb/tb_alu_register_bank.sv
// Directed-vector bench for alu_register_bank: reset contents, ALU ops, flags, write timing, async reset.
module tb_alu_register_bank;
  logic clk = 1'b0;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;

  alu_register_bank_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  alu_register_bank #(.DATA_W(32), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
    @(negedge clk);
    bus.write_reg    = adr;
    bus.write_data   = dat;
    bus.write_enable = 1'b1;
    @(posedge clk);
    #1;
    bus.write_enable = 1'b0;
  endtask

  task automatic alu(input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] op);
    bus.read_reg1 = ra;
    bus.read_reg2 = rb;
    bus.opcode    = op;
    #1;
  endtask

  initial begin
    rst              = 1'b0;
    bus.read_reg1    = '0;
    bus.read_reg2    = '0;
    bus.write_reg    = '0;
    bus.write_data   = '0;
    bus.write_enable = 1'b0;
    bus.opcode       = '0;
    #1 rst = 1'b1;
    #10;
    @(negedge clk) rst = 1'b0;

    // reset contents
    for (int i = 0; i < 16; i++) begin
      alu(i[3:0], 4'(15 - i), 4'h0);
`ifdef REG_ZERO_HARDWIRED_EN
      chk("rst_r1", bus.data_out1, 32'(i));
`else
      chk("rst_r1", bus.data_out1, 32'(i));
`endif
      chk("rst_r2", bus.data_out2, 32'(15 - i));
    end

    // basic ops on R1=1, R2=2
    alu(4'd1, 4'd2, 4'h0);
    chk("out1", bus.data_out1, 32'd1);
    chk("out2", bus.data_out2, 32'd2);
    chk("add", bus.alu_result, 32'd3);
    chk("add_z", 32'(bus.zero_flag), 32'd0);
    alu(4'd1, 4'd2, 4'h1);
    chk("sub", bus.alu_result, 32'hFFFF_FFFF);
    chk("sub_c", 32'(bus.carry_flag), 32'd0);
    chk("sub_n", 32'(bus.negative_flag), 32'd1);
    chk("sub_v", 32'(bus.overflow_flag), 32'd0);
    alu(4'd1, 4'd2, 4'h2);
    chk("and", bus.alu_result, 32'd0);
    chk("and_z", 32'(bus.zero_flag), 32'd1);
    alu(4'd1, 4'd2, 4'h3); chk("or",   bus.alu_result, 32'd3);
    alu(4'd1, 4'd2, 4'h4); chk("xor",  bus.alu_result, 32'd3);
    alu(4'd1, 4'd2, 4'h5); chk("nor",  bus.alu_result, 32'hFFFF_FFFC);
    alu(4'd1, 4'd2, 4'h6); chk("not",  bus.alu_result, 32'hFFFF_FFFE);
    alu(4'd1, 4'd2, 4'h7); chk("sll",  bus.alu_result, 32'd4);
    alu(4'd1, 4'd2, 4'hA); chk("slt",  bus.alu_result, 32'd1);
    alu(4'd2, 4'd1, 4'hB); chk("sltu", bus.alu_result, 32'd0);
    alu(4'd1, 4'd2, 4'hC); chk("inc",  bus.alu_result, 32'd2);
    alu(4'd1, 4'd2, 4'hD);
    chk("dec", bus.alu_result, 32'd0);
    chk("dec_c", 32'(bus.carry_flag), 32'd1);
    chk("dec_z", 32'(bus.zero_flag), 32'd1);
    alu(4'd1, 4'd2, 4'hE); chk("pasa", bus.alu_result, 32'd1);
    alu(4'd1, 4'd2, 4'hF); chk("pasb", bus.alu_result, 32'd2);
    alu(4'd0, 4'd0, 4'hD);
    chk("dec0", bus.alu_result, 32'hFFFF_FFFF);
    chk("dec0_c", 32'(bus.carry_flag), 32'd0);

    // write timing, no bypass
    wr(4'd3, 32'd3);
    alu(4'd3, 4'd0, 4'h0); chk("w3", bus.data_out1, 32'd3);
    @(negedge clk);
    bus.write_reg = 4'd4; bus.write_data = 32'h1234_5678; bus.write_enable = 1'b1;
    alu(4'd4, 4'd4, 4'hF);
    chk("w4_before", bus.data_out1, 32'd4);
    chk("w4_before_alu", bus.alu_result, 32'd4);
    @(posedge clk); #1;
    bus.write_enable = 1'b0;
    chk("w4_after", bus.data_out1, 32'h1234_5678);
    chk("w4_after_alu", bus.alu_result, 32'h1234_5678);

    // signed overflow
    wr(4'd1, 32'h7FFF_FFFF);
    wr(4'd2, 32'd1);
    alu(4'd1, 4'd2, 4'h0);
    chk("ovf", bus.alu_result, 32'h8000_0000);
    chk("ovf_v", 32'(bus.overflow_flag), 32'd1);
    chk("ovf_c", 32'(bus.carry_flag), 32'd0);
    chk("ovf_n", 32'(bus.negative_flag), 32'd1);
    alu(4'd1, 4'd2, 4'hC);
    chk("inc_v", 32'(bus.overflow_flag), 32'd1);

    // unsigned carry
    wr(4'd1, 32'hFFFF_FFFF);
    alu(4'd1, 4'd2, 4'h0);
    chk("cry", bus.alu_result, 32'd0);
    chk("cry_c", 32'(bus.carry_flag), 32'd1);
    chk("cry_z", 32'(bus.zero_flag), 32'd1);
    chk("cry_v", 32'(bus.overflow_flag), 32'd0);
    alu(4'd1, 4'd2, 4'h3);
    chk("or_c", 32'(bus.carry_flag), 32'd0);

    // shifts and signed compares
    wr(4'd1, 32'h8000_0000);
    wr(4'd2, 32'd4);
    alu(4'd1, 4'd2, 4'h9); chk("sra", bus.alu_result, 32'hF800_0000);
    alu(4'd1, 4'd2, 4'h8); chk("srl", bus.alu_result, 32'h0800_0000);
    alu(4'd1, 4'd2, 4'hA); chk("slt_neg", bus.alu_result, 32'd1);
    alu(4'd1, 4'd2, 4'hB); chk("sltu_big", bus.alu_result, 32'd0);
    alu(4'd1, 4'd2, 4'h1);
    chk("sub_ov", bus.alu_result, 32'h7FFF_FFFC);
    chk("sub_ov_v", 32'(bus.overflow_flag), 32'd1);
    chk("sub_ov_c", 32'(bus.carry_flag), 32'd1);

    // R0 behaviour depends on build option
    wr(4'd0, 32'h55);
    alu(4'd0, 4'd0, 4'h0);
`ifdef REG_ZERO_HARDWIRED_EN
    chk("r0", bus.data_out1, 32'd0);
`else
    chk("r0", bus.data_out1, 32'h55);
`endif

    // async reset mid-cycle drops a concurrent write
    @(negedge clk);
    bus.write_reg = 4'd5; bus.write_data = 32'hDEAD_BEEF; bus.write_enable = 1'b1;
    #1 rst = 1'b1;
    alu(4'd1, 4'd4, 4'h0);
    chk("arst_r1", bus.data_out1, 32'd1);
    chk("arst_r4", bus.data_out2, 32'd4);
    @(posedge clk); #1;
    alu(4'd5, 4'd0, 4'h0);
    chk("arst_nowr", bus.data_out1, 32'd5);
    @(negedge clk);
    bus.write_enable = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      alu(i[3:0], 4'd0, 4'h0);
      chk("arst_all", bus.data_out1, 32'(i));
    end
    alu(4'd1, 4'd2, 4'h0);
    chk("arst_add", bus.alu_result, 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
